// File: rtl/pll_lock_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_pkg
// Shared types and constants for the PLL lock supervisor.
//   state_t   : supervisor FSM states
//   RETRY_W   : width of the failed-attempt counter
//   LOSS_W    : width of the lock-loss event counter
//   cnt_width : width of the shared phase counter, sized for the largest
//               of the three cycle-count parameters
// ---------------------------------------------------------------------------
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // The counter only has to reach (max - 1), so clog2(max) bits suffice.
  // A minimum of one bit keeps the vector legal when every parameter is 1.
  function automatic int cnt_width(input int unsigned a,
                                   input int unsigned b,
                                   input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
// Groups the PLL-facing and downstream-facing signals of the supervisor.
//   locked        PLL locked indication (asynchronous to refclk)
//   force_relock  single-cycle request to restart the lock sequence
//   pll_rst       reset driven into the PLL
//   sys_rst_out   downstream reset, high until lock is stable
//   ready         lock is stable and downstream reset released
//   fail          supervisor gave up after too many failed attempts
//   retry_count   failed attempts since last RUN / force_relock
//   lock_lost     one-cycle pulse when lock drops while running
//   loss_count    saturating count of lock_lost events
// Modports:
//   master : the supervisor (drives the status/reset outputs)
//   slave  : the environment (drives locked / force_relock)
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  import pll_lock_supervisor_pkg::*;

  logic               locked;
  logic               force_relock;
  logic               pll_rst;
  logic               sys_rst_out;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_count;
  logic               lock_lost;
  logic [LOSS_W-1:0]  loss_count;

  modport master (
    input  locked,
    input  force_relock,
    output pll_rst,
    output sys_rst_out,
    output ready,
    output fail,
    output retry_count,
    output lock_lost,
    output loss_count
  );

  modport slave (
    output locked,
    output force_relock,
    input  pll_rst,
    input  sys_rst_out,
    input  ready,
    input  fail,
    input  retry_count,
    input  lock_lost,
    input  loss_count
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer with synchronous active-high reset to 0.
//   clk   destination clock
//   srst  synchronous reset, active high
//   d     asynchronous input
//   q     synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  // stage_reg[0] may go metastable; stage_reg[1] is the settled copy.
  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      stage_reg <= 2'b00;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the PLL reset, waits for a stable lock (with timeout and retry) and
// only then releases the downstream reset for the PLL output clock domain.
// Runs entirely on refclk.
//   refclk  reference clock (sole clock)
//   rst     synchronous active-high reset
//   bus     pll_lock_supervisor_if.master: locked/force_relock in,
//           pll_rst/sys_rst_out/ready/fail/retry_count/lock_lost/loss_count out
// Build option:
//   LOCK_LOSS_COUNT_EN  when defined, builds the saturating loss_count
//                       register; otherwise loss_count is tied to zero.
// ---------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_lock_supervisor_if.master  bus
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                   LOCK_TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [RETRY_W-1:0] retry_inc;
  logic               lock_lost_reg, lock_lost_next;
  logic               attempt_failed;
  logic               locked_s;

  sync_2ff u_locked_sync (
    .clk  (refclk),
    .srst (rst),
    .d    (bus.locked),
    .q    (locked_s)
  );

  assign retry_inc = retry_reg + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    retry_next     = retry_reg;
    lock_lost_next = 1'b0;
    attempt_failed = 1'b0;

    if (bus.force_relock) begin
      // A deliberate restart is not a lock loss, so no lock_lost pulse.
      state_next = PLL_RST;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      unique case (state_reg)
        PLL_RST: begin
          // locked_s is deliberately ignored while the PLL is held in reset.
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            attempt_failed = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        STABLE: begin
          // Any glitch in lock during the qualification window aborts it.
          if (!locked_s) begin
            attempt_failed = 1'b1;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_next     = PLL_RST;
            cnt_next       = '0;
            lock_lost_next = 1'b1;
          end
        end

        FAIL: begin
          // Held until rst or force_relock.
        end

        default: begin
          state_next = PLL_RST;
          cnt_next   = '0;
        end
      endcase

      if (attempt_failed) begin
        retry_next = retry_inc;
        cnt_next   = '0;
        state_next = (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock-loss event counter
  // ---------------------------------------------------------------------------
`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_count_reg;

  // Counts on the same edge that raises lock_lost; holds at all-ones.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_count_reg <= '0;
    end else if (lock_lost_next && (loss_count_reg != {LOSS_W{1'b1}})) begin
      loss_count_reg <= loss_count_reg + 1'b1;
    end
  end

  assign bus.loss_count = loss_count_reg;
`else
  assign bus.loss_count = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs, decoded only from registered state
  // ---------------------------------------------------------------------------
  assign bus.pll_rst     = (state_reg == PLL_RST);
  assign bus.sys_rst_out = (state_reg != RUN);
  assign bus.ready       = (state_reg == RUN);
  assign bus.fail        = (state_reg == FAIL);
  assign bus.retry_count = retry_reg;
  assign bus.lock_lost   = lock_lost_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Self-checking bench for pll_lock_supervisor with RST_PULSE_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
// A phase/elapsed-time model of the supervisor is compared against every
// DUT output on each falling edge; directed scenarios add hand-computed
// literal expectations. Expected loss_count follows LOCK_LOSS_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RST_P = 4;
  localparam int STB   = 8;
  localparam int TO    = 32;
  localparam int MAXR  = 2;

`ifdef LOCK_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic refclk = 1'b0;
  logic rst;
  logic locked;
  logic force_relock;

  pll_lock_supervisor_if bus ();

  assign bus.locked       = locked;
  assign bus.force_relock = force_relock;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #10 refclk = ~refclk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: phase plus cycles spent in it; locked seen through a
  // two-edge delay line.
  // -------------------------------------------------------------------------
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3, PH_DEAD = 4;

  int ph       = PH_PULSE;
  int in_phase = 0;
  int m_retry  = 0;
  int m_losses = 0;
  bit m_lost   = 1'b0;
  bit seen1    = 1'b0;
  bit seen2    = 1'b0;

  function automatic void go(input int p);
    ph       = p;
    in_phase = 0;
  endfunction

  function automatic void attempt_failed();
    m_retry = m_retry + 1;
    go((m_retry >= MAXR) ? PH_DEAD : PH_PULSE);
  endfunction

  always @(posedge refclk) begin
    bit ls;
    cyc    = cyc + 1;
    ls     = seen2;
    m_lost = 1'b0;
    if (rst) begin
      go(PH_PULSE);
      m_retry  = 0;
      m_losses = 0;
      seen1    = 1'b0;
      seen2    = 1'b0;
    end else begin
      seen2 = seen1;
      seen1 = locked;
      if (force_relock) begin
        go(PH_PULSE);
        m_retry = 0;
      end else begin
        in_phase = in_phase + 1;
        case (ph)
          PH_PULSE: if (in_phase == RST_P) go(PH_WAIT);
          PH_WAIT: begin
            if (ls) go(PH_QUAL);
            else if (in_phase == TO) attempt_failed();
          end
          PH_QUAL: begin
            if (!ls) attempt_failed();
            else if (in_phase == STB) begin
              go(PH_RUN);
              m_retry = 0;
            end
          end
          PH_RUN: begin
            if (!ls) begin
              go(PH_PULSE);
              m_lost   = 1'b1;
              m_losses = m_losses + 1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge refclk) begin
    if (cyc > 0) begin
      check("pll_rst",     bus.pll_rst,     (ph == PH_PULSE) ? 1 : 0);
      check("sys_rst_out", bus.sys_rst_out, (ph != PH_RUN)   ? 1 : 0);
      check("ready",       bus.ready,       (ph == PH_RUN)   ? 1 : 0);
      check("fail",        bus.fail,        (ph == PH_DEAD)  ? 1 : 0);
      check("retry_count", bus.retry_count, m_retry);
      check("lock_lost",   bus.lock_lost,   m_lost);
      check("loss_count",  bus.loss_count,
            LOSS_EN ? ((m_losses > 255) ? 255 : m_losses) : 0);
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int limit, output int k);
    k = 0;
    while (!bus.ready && k < limit) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_lost(input int limit, output int k);
    k = 0;
    while (!bus.lock_lost && k < limit) begin
      tick(1);
      k++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    int n, k, t, r40, bad;
    bit seen_ready;

    rst = 1'b1; locked = 1'b0; force_relock = 1'b0;
    tick(3);
    check("reset pll_rst",     bus.pll_rst,     1);
    check("reset sys_rst_out", bus.sys_rst_out, 1);
    check("reset ready",       bus.ready,       0);
    check("reset fail",        bus.fail,        0);
    check("reset retry_count", bus.retry_count, 0);
    check("reset lock_lost",   bus.lock_lost,   0);
    check("reset loss_count",  bus.loss_count,  0);
    $display("[TB] reset: pll_rst=%0d sys_rst_out=%0d", bus.pll_rst, bus.sys_rst_out);

    // 1. Nominal lock
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.pll_rst) n++;
      tick(1);
    end
    check("nominal pll_rst width", n, 4);
    locked = 1'b1;
    wait_ready(40, k);
    check("nominal lock-to-ready edges", k, 11);
    check("nominal sys_rst_out", bus.sys_rst_out, 0);
    check("nominal retry_count", bus.retry_count, 0);
    $display("[TB] nominal lock: pll_rst width %0d, ready after %0d edges", n, k);

    // 4. Loss in RUN
    tick(2);
    locked = 1'b0;
    wait_lost(20, k);
    check("loss lock_lost delay", k, 3);
    check("loss sys_rst_out", bus.sys_rst_out, 1);
    check("loss ready", bus.ready, 0);
    check("loss loss_count", bus.loss_count, LOSS_EN ? 1 : 0);
    tick(1);
    check("loss pulse width", bus.lock_lost, 0);
    locked = 1'b1;
    wait_ready(60, k);
    check("loss relock ready", bus.ready, 1);
    $display("[TB] lock loss in run: relocked after %0d edges, loss_count=%0d", k, bus.loss_count);

    // 5a. force_relock from RUN (with lock dropping at the same time)
    tick(2);
    force_relock = 1'b1;
    locked = 1'b0;
    tick(1);
    force_relock = 1'b0;
    check("force-run pll_rst", bus.pll_rst, 1);
    check("force-run retry_count", bus.retry_count, 0);
    check("force-run lock_lost", bus.lock_lost, 0);
    check("force-run ready", bus.ready, 0);
    $display("[TB] force_relock from run: pll_rst=%0d lock_lost=%0d", bus.pll_rst, bus.lock_lost);

    // 3. Unstable lock during qualification
    k = 0;
    while (bus.pll_rst && k < 20) begin
      tick(1);
      k++;
    end
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    seen_ready = 1'b0;
    k = 0;
    while (!bus.pll_rst && k < 20) begin
      if (bus.ready) seen_ready = 1'b1;
      tick(1);
      k++;
    end
    check("unstable abort delay", k, 3);
    check("unstable no ready", seen_ready, 0);
    check("unstable retry_count", bus.retry_count, 1);
    n = 0;
    while (bus.pll_rst && n < 20) begin
      n++;
      tick(1);
    end
    check("unstable pll_rst width", n, 4);
    $display("[TB] unstable lock: retry_count=%0d, new pll_rst width %0d", bus.retry_count, n);

    // 2. Timeout to fail state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t = 0;
    r40 = 0;
    while (!bus.fail && t < 200) begin
      if (t == 40) r40 = bus.retry_count;
      tick(1);
      t++;
    end
    check("timeout fail cycle", t, 72);
    check("timeout retry after first", r40, 1);
    check("timeout retry_count", bus.retry_count, 2);
    check("timeout pll_rst", bus.pll_rst, 0);
    check("timeout sys_rst_out", bus.sys_rst_out, 1);
    tick(5);
    check("timeout fail held", bus.fail, 1);
    $display("[TB] timeout: fail at cycle %0d, retry_count=%0d", t, bus.retry_count);

    // 5b. Simultaneous rst + force_relock, then force_relock from FAIL
    rst = 1'b1;
    force_relock = 1'b1;
    tick(1);
    rst = 1'b0;
    force_relock = 1'b0;
    check("rst+force pll_rst", bus.pll_rst, 1);
    check("rst+force fail", bus.fail, 0);
    check("rst+force retry_count", bus.retry_count, 0);
    check("rst+force lock_lost", bus.lock_lost, 0);
    check("rst+force loss_count", bus.loss_count, 0);
    t = 0;
    while (!bus.fail && t < 200) begin
      tick(1);
      t++;
    end
    check("refail cycle", t, 72);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("force-fail pll_rst", bus.pll_rst, 1);
    check("force-fail fail", bus.fail, 0);
    check("force-fail retry_count", bus.retry_count, 0);
    check("force-fail sys_rst_out", bus.sys_rst_out, 1);
    $display("[TB] force_relock from fail: pll_rst=%0d retry_count=%0d", bus.pll_rst, bus.retry_count);

    // 6. loss_count saturation
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      wait_ready(60, k);
      if (!bus.ready) bad++;
      locked = 1'b0;
      wait_lost(10, k);
      if (!bus.lock_lost) bad++;
    end
    check("saturation bounded waits", bad, 0);
    check("saturation loss_count", bus.loss_count, LOSS_EN ? 255 : 0);
    $display("[TB] saturation: 260 loss events, loss_count=%0d", bus.loss_count);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
